// File: rtl/tlc_two_road.sv
// tlc_two_road: two-road traffic-light controller (main road / side road).
// A seconds prescaler drives a phase timer that walks the main and side roads
// through green, yellow and all-red clearance. There is a night flashing mode
// and a clock-enable that freezes the whole controller. The controller also
// exposes its phase and the ticks remaining, for display and debug.
// Optional feature macro: TLC_PED_EN adds the pedestrian request latch, the
// PED_WALK phase and the walk lamp. When it is undefined, ped_req is ignored
// and walk is tied low.
module tlc_two_road #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int GREEN_S       = 20,
  parameter int YELLOW_S      = 3,
  parameter int ALLRED_S      = 2,
  parameter int PED_S         = 10,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic [2:0]       main_rgy,
  output logic [2:0]       side_rgy,
  output logic             walk,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] sec_left,
  output logic             tick
);

  typedef enum logic [2:0] {
    M_GREEN   = 3'd0,
    M_YELLOW  = 3'd1,
    ALL_RED_1 = 3'd2,
    S_GREEN   = 3'd3,
    S_YELLOW  = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_e;

  localparam int              PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] DUR_GREEN  = CNT_W'(GREEN_S);
  localparam logic [CNT_W-1:0] DUR_YELLOW = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] DUR_ALLRED = CNT_W'(ALLRED_S);
  localparam logic [CNT_W-1:0] DUR_PED    = CNT_W'(PED_S);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Phase duration loaded into the timer on entry to a state
  function automatic logic [CNT_W-1:0] dur_of(input state_e st);
    logic [CNT_W-1:0] d;
    case (st)
      M_GREEN, S_GREEN:   d = DUR_GREEN;
      M_YELLOW, S_YELLOW: d = DUR_YELLOW;
      PED_WALK:           d = DUR_PED;
      FLASH:              d = CNT_ZERO;
      default:            d = DUR_ALLRED;
    endcase
    return d;
  endfunction

  // Lamp decode {main_rgy, side_rgy, walk} from a state and flash bit.
  // Encoding 6 without the pedestrian feature falls into the all-red default.
  function automatic logic [6:0] lamp_decode(input state_e st, input logic fl);
    logic [6:0] l;
    case (st)
      M_GREEN:  l = {3'b001, 3'b100, 1'b0};
      M_YELLOW: l = {3'b010, 3'b100, 1'b0};
      S_GREEN:  l = {3'b100, 3'b001, 1'b0};
      S_YELLOW: l = {3'b100, 3'b010, 1'b0};
      FLASH:    l = {1'b0, fl, 1'b0, fl, 1'b0, 1'b0, 1'b0};
`ifdef TLC_PED_EN
      PED_WALK: l = {3'b100, 3'b100, 1'b1};
`endif
      default:  l = {3'b100, 3'b100, 1'b0};
    endcase
    return l;
  endfunction

  logic [PW-1:0]    presc_r;
  logic             tick_s;
  state_e           state_r;
  state_e           state_nx_s;
  logic [CNT_W-1:0] sec_left_r;
  logic [CNT_W-1:0] sec_nx_s;
  logic             flash_r;
  logic             flash_nx_s;
  logic [6:0]       lamp_r;
  logic [6:0]       lamp_nx_s;
  logic             ped_pending_s;
`ifdef TLC_PED_EN
  logic             ped_pending_r;
  logic             ped_nx_s;
  assign ped_pending_s = ped_pending_r;
`else
  logic             unused_ped_req_s;
  assign ped_pending_s    = 1'b0;
  assign unused_ped_req_s = ped_req;
`endif

  // The tick is combinational so that it lines up with the last prescaler count
  assign tick_s = enable & (presc_r == PRESC_MAX);

  // Prescaler: counts clk cycles per second and holds while enable is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= {PW{1'b0}};
    end else if (enable) begin
      presc_r <= (presc_r == PRESC_MAX) ? {PW{1'b0}} : presc_r + PW'(1);
    end
  end

  // Next-state, timer and flash logic; everything advances only on a tick
  always_comb begin
    state_nx_s = state_r;
    sec_nx_s   = sec_left_r;
    flash_nx_s = flash_r;
`ifdef TLC_PED_EN
    ped_nx_s   = ped_pending_r | (enable & ped_req);
`endif
    if (tick_s) begin
      if (state_r == FLASH) begin
        if (night_mode) begin
          flash_nx_s = ~flash_r;
          sec_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = ALL_RED_2;
          sec_nx_s   = DUR_ALLRED;
          flash_nx_s = 1'b0;
        end
      end else if (sec_left_r > CNT_ONE) begin
        sec_nx_s = sec_left_r - CNT_ONE;
      end else begin
        case (state_r)
          M_GREEN:   state_nx_s = M_YELLOW;
          M_YELLOW:  state_nx_s = ALL_RED_1;
          ALL_RED_1: state_nx_s = night_mode ? FLASH : S_GREEN;
          S_GREEN:   state_nx_s = S_YELLOW;
          S_YELLOW:  state_nx_s = ALL_RED_2;
`ifdef TLC_PED_EN
          PED_WALK:  state_nx_s = M_GREEN;
`endif
          default: begin
            // ALL_RED_2 exit; unreachable encodings recover the same way
            if (night_mode) begin
              state_nx_s = FLASH;
            end else if (ped_pending_s) begin
              state_nx_s = PED_WALK;
            end else begin
              state_nx_s = M_GREEN;
            end
          end
        endcase
        sec_nx_s = dur_of(state_nx_s);
`ifdef TLC_PED_EN
        // Entering the walk consumes the request, even one raised this clk
        if (state_nx_s == PED_WALK) begin
          ped_nx_s = 1'b0;
        end else begin
          ped_nx_s = ped_pending_r | (enable & ped_req);
        end
`endif
      end
    end else begin
      sec_nx_s = sec_left_r;
    end
    lamp_nx_s = lamp_decode(state_nx_s, flash_nx_s);
  end

  // Phase register, timer, flash bit and registered lamp drivers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ALL_RED_2;
      sec_left_r <= DUR_ALLRED;
      flash_r    <= 1'b0;
      lamp_r     <= {3'b100, 3'b100, 1'b0};
    end else begin
      state_r    <= state_nx_s;
      sec_left_r <= sec_nx_s;
      flash_r    <= flash_nx_s;
      lamp_r     <= lamp_nx_s;
    end
  end

`ifdef TLC_PED_EN
  // Pedestrian request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pending_r <= 1'b0;
    end else begin
      ped_pending_r <= ped_nx_s;
    end
  end
`endif

  assign main_rgy = lamp_r[6:4];
  assign side_rgy = lamp_r[3:1];
  assign walk     = lamp_r[0];
  assign phase    = state_r;
  assign sec_left = sec_left_r;
  assign tick     = tick_s;

endmodule

// File: tb/tb_tlc_two_road.sv
// Testbench for tlc_two_road with small timing parameters. A bench-side
// reference model predicts the outputs for each clock. The prediction is
// queued when the inputs for that clock are driven, then popped and compared
// after the edge. Works with or without TLC_PED_EN defined.
module tb_tlc_two_road;

  localparam int TPS = 4;
  localparam int G   = 5;
  localparam int Y   = 2;
  localparam int AR  = 1;
  localparam int PD  = 3;
  localparam int CW  = 4;
`ifdef TLC_PED_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          night_mode;
  logic          ped_req;
  logic [2:0]    main_rgy;
  logic [2:0]    side_rgy;
  logic          walk;
  logic [2:0]    phase;
  logic [CW-1:0] sec_left;
  logic          tick;

  tlc_two_road #(
    .TICKS_PER_SEC(TPS), .GREEN_S(G), .YELLOW_S(Y),
    .ALLRED_S(AR), .PED_S(PD), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .night_mode(night_mode),
    .ped_req(ped_req), .main_rgy(main_rgy), .side_rgy(side_rgy),
    .walk(walk), .phase(phase), .sec_left(sec_left), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] sl;
    logic [6:0] lamps;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int m_presc, m_ph, m_sec;
  bit m_flash, m_ped;

  // DUT observations for phase-length checks
  int cyc_n = 0, prev_ph = 5, green_run = 0, last_green = 0;
  int round_start = 0, last_round = 0, walk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [6:0] exp_lamps(input int ph, input bit fl);
    case (ph)
      0:       return 7'b001_100_0;
      1:       return 7'b010_100_0;
      3:       return 7'b100_001_0;
      4:       return 7'b100_010_0;
      6:       return PED_ON ? 7'b100_100_1 : 7'b100_100_0;
      7:       return {1'b0, fl, 1'b0, fl, 3'b000};
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic int mdur(input int ph);
    case (ph)
      0, 3:    return G;
      1, 4:    return Y;
      6:       return PD;
      7:       return 0;
      default: return AR;
    endcase
  endfunction

  task automatic m_reset();
    m_presc = 0; m_ph = 5; m_sec = AR; m_flash = 1'b0; m_ped = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    bit tk;
    bit ped_n;
    int nx;
    tk    = enable && (m_presc == TPS - 1);
    ped_n = PED_ON && (m_ped || (enable && ped_req));
    if (tk) begin
      if (m_ph == 7) begin
        if (night_mode) m_flash = ~m_flash;
        else begin m_ph = 5; m_sec = AR; m_flash = 1'b0; end
      end else if (m_sec > 1) begin
        m_sec = m_sec - 1;
      end else begin
        case (m_ph)
          0: nx = 1;
          1: nx = 2;
          2: nx = night_mode ? 7 : 3;
          3: nx = 4;
          4: nx = 5;
          6: nx = 0;
          default: nx = night_mode ? 7 : ((PED_ON && m_ped) ? 6 : 0);
        endcase
        if (nx == 6) ped_n = 1'b0;
        m_ph  = nx;
        m_sec = mdur(nx);
      end
    end
    m_ped = ped_n;
    if (enable) m_presc = (m_presc == TPS - 1) ? 0 : m_presc + 1;
  endtask

  // One clock: check tick, queue prediction, clock, pop and compare
  task automatic cyc();
    exp_t e;
    check_val("tick", {31'd0, tick}, {31'd0, (reset && enable && m_presc == TPS - 1)});
    if (!reset) m_reset();
    else model_step();
    e.ph    = 3'(m_ph);
    e.sl    = 4'(m_sec);
    e.lamps = exp_lamps(m_ph, m_flash);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    e = exp_q.pop_front();
    check_val("phase", {29'd0, phase}, {29'd0, e.ph});
    check_val("sec_left", {28'd0, sec_left}, {28'd0, e.sl});
    check_val("main_rgy", {29'd0, main_rgy}, {29'd0, e.lamps[6:4]});
    check_val("side_rgy", {29'd0, side_rgy}, {29'd0, e.lamps[3:1]});
    check_val("walk", {31'd0, walk}, {31'd0, e.lamps[0]});
    if (walk) walk_cnt++;
    if (phase == 3'd0) green_run++;
    else begin
      if (prev_ph == 0) last_green = green_run;
      green_run = 0;
    end
    if (phase == 3'd0 && prev_ph != 0) begin
      last_round  = cyc_n - round_start;
      round_start = cyc_n;
    end
    prev_ph = phase;
  endtask

  // Run clocks until the model reaches a phase, bounded
  task automatic wait_ph(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_ph == target) begin hit = 1'b1; break; end
      cyc();
    end
    check_val("wait_phase_reached", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int walks0;
    reset = 1'b0; enable = 1'b1; night_mode = 1'b0; ped_req = 1'b0;
    m_reset();
    @(negedge clk);
    repeat (3) cyc();
    reset = 1'b1;

    // Plain rounds: reset phase 5 for 4 clk, then 0..5 every 64 clk
    repeat (140) cyc();
    check_val("round_len", last_round, 64);
    check_val("green_len", last_green, 4 * G);

    // Pedestrian pulse in M_GREEN, then a second pulse during the walk
    walks0 = walk_cnt;
    wait_ph(0);
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
    if (PED_ON) begin
      wait_ph(6);
      ped_req = 1'b1; cyc(); ped_req = 1'b0;
    end
    repeat (170) cyc();
    check_val("walk_clks", walk_cnt - walks0, PED_ON ? 2 * PD * TPS : 0);

    // Night mode raised in S_GREEN, dropped after a few flashes
    wait_ph(3);
    night_mode = 1'b1;
    wait_ph(7);
    repeat (22) cyc();
    night_mode = 1'b0;
    wait_ph(0);

    // Clock-enable stall of 10 clk inside M_GREEN
    repeat (8) cyc();
    enable = 1'b0;
    repeat (10) cyc();
    enable = 1'b1;
    wait_ph(1);
    check_val("green_len_stalled", last_green, 4 * G + 10);

    // ped_req held for a full round
    ped_req = 1'b1;
    wait_ph(0);
    wait_ph(1);
    wait_ph(0);
    check_val("round_len_ped_held", last_round, PED_ON ? 64 + 4 * PD : 64);
    ped_req = 1'b0;
    repeat (80) cyc();

    // Asynchronous reset in S_YELLOW with a pending pedestrian request
    wait_ph(3);
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
    wait_ph(4);
    cyc();
    #2 reset = 1'b0;
    #1;
    check_val("async_phase", {29'd0, phase}, 32'd5);
    check_val("async_sec_left", {28'd0, sec_left}, 32'd1);
    check_val("async_main", {29'd0, main_rgy}, 32'd4);
    check_val("async_side", {29'd0, side_rgy}, 32'd4);
    check_val("async_walk", {31'd0, walk}, 32'd0);
    check_val("async_tick", {31'd0, tick}, 32'd0);
    m_reset();
    repeat (2) cyc();
    reset = 1'b1;
    walks0 = walk_cnt;
    repeat (100) cyc();
    check_val("walk_after_reset", walk_cnt - walks0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlc_two_road.md
Name: tlc_two_road

Overview:
Parametrised two-road traffic-light controller that succeeds the single-approach fixed-20 s controller. It drives a main road and a side road with configurable green, yellow and all-red clearance times. It adds a pedestrian walk phase, a night flashing mode and a clock-enable, and exposes phase and seconds-remaining for display and debug. It sits between the board clock and LED/driver pins.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per 1 s tick; must be >= 2
GREEN_S, 20, green duration per road in ticks; must be >= 1
YELLOW_S, 3, yellow duration in ticks; must be >= 1
ALLRED_S, 2, all-red clearance in ticks; must be >= 1
PED_S, 10, pedestrian walk duration in ticks; must be >= 1
CNT_W, 8, width of sec_left; must hold the largest duration

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  1 = run; 0 = freeze prescaler, timer and phase
night_mode  in  1  request flashing mode
ped_req  in  1  pedestrian button, level, sampled every clk
main_rgy  out  3  main road lamps {red, yellow, green}
side_rgy  out  3  side road lamps {red, yellow, green}
walk  out  1  pedestrian walk lamp
phase  out  3  current state encoding
sec_left  out  CNT_W  ticks remaining in the current phase
tick  out  1  one-clk pulse per second

Behaviour:
- Prescaler counts 0..TICKS_PER_SEC-1 while enable=1.
  - tick=1 for exactly the clk in which the count equals TICKS_PER_SEC-1; the count then wraps to 0.
  - enable=0 holds the count, forces tick=0 and holds all state.
- States and encoding: M_GREEN=0, M_YELLOW=1, ALL_RED_1=2, S_GREEN=3, S_YELLOW=4, ALL_RED_2=5, PED_WALK=6, FLASH=7.
- On entry to a state, sec_left loads that state's duration.
- On each tick:
  - if sec_left > 1: decrement.
  - if sec_left == 1: transition to the next state and load its duration.
  - Each phase therefore lasts exactly its duration in ticks.
- Transitions:
  - M_GREEN -> M_YELLOW -> ALL_RED_1 -> S_GREEN -> S_YELLOW -> ALL_RED_2.
  - ALL_RED_2 exit, in priority order: FLASH if night_mode=1; else PED_WALK if ped_pending; else M_GREEN.
  - ALL_RED_1 exit: FLASH if night_mode=1; else S_GREEN.
  - PED_WALK -> M_GREEN.
- FLASH:
  - sec_left is held at 0.
  - A flash bit toggles on every tick.
  - main_rgy = {0, flash, 0}; side_rgy = {flash, 0, 0}; walk = 0.
  - On a tick with night_mode=0: go to ALL_RED_2 with sec_left=ALLRED_S and flash cleared.
- night_mode asserted in any other state has no effect until the next all-red exit.
- ped_pending:
  - Set in any clk where ped_req=1.
  - Cleared in the clk of entry to PED_WALK; the clear wins over a simultaneous set.
  - A request raised during PED_WALK is served on the following cycle round.
- Lamp decode (decoded from registered state and flash bit only; glitch-free):
  - M_GREEN: main 001, side 100.
  - M_YELLOW: main 010, side 100.
  - S_GREEN: main 100, side 001.
  - S_YELLOW: main 100, side 010.
  - ALL_RED_x and PED_WALK: main 100, side 100.
  - walk = 1 only in PED_WALK.
- Reset (asynchronous assert, synchronous-safe deassert):
  - State = ALL_RED_2, sec_left = ALLRED_S, prescaler = 0, tick = 0, ped_pending = 0, flash = 0.
  - Resulting outputs: main 100, side 100, walk 0, phase 5.
  - Reset mid-phase takes effect immediately, in any state.
- Normal round without ped or night: 2*(GREEN_S+YELLOW_S+ALLRED_S) ticks.

Optional Feature:
TLC_PED_EN
- Defined: ped_req latch, PED_WALK state and walk output behave as above.
- Undefined: ped_pending logic and PED_WALK are removed; ped_req is ignored; walk is tied 0; ALL_RED_2 exits only to FLASH or M_GREEN; encoding 6 is unreachable and decodes as ALL_RED_2.

Test Plan:
Params TICKS_PER_SEC=4, GREEN_S=5, YELLOW_S=2, ALLRED_S=1, PED_S=3, CNT_W=4.
1. Release reset, enable=1 -> phase=5, sec_left=1 for 4 clk; first tick enters M_GREEN with sec_left=5; phase sequence 0,1,2,3,4,5 repeats every 16 ticks (64 clk).
2. One-clk ped_req pulse during M_GREEN (macro defined) -> after ALL_RED_2: PED_WALK for 3 ticks, walk=1, main/side 100; then M_GREEN; a second pulse during PED_WALK yields another walk on the next round.
3. night_mode=1 raised during S_GREEN -> S_YELLOW and ALL_RED_2 complete, then FLASH; main yellow and side red toggle every tick, sec_left=0; drop night_mode -> next tick ALL_RED_2 for 1 tick, then M_GREEN.
4. enable=0 for 10 clk mid-M_GREEN -> sec_left, prescaler, phase and outputs frozen, tick=0; M_GREEN lasts 20+10 clk total.
5. reset driven low mid-S_YELLOW, asynchronous to clk -> outputs go to main 100, side 100, phase 5, sec_left=1 without waiting for a clk edge; ped_pending is cleared.
6. Macro undefined, ped_req held 1 for a full round -> no PED_WALK; walk stays 0; round length is 16 ticks.
